spi_master: RTL and testbench
=============================

Name: spi_master

Overview:
- SPI master that generates SCK, CSbar and MOSI and captures MISO. It sits at the other end of the link from the team's 16-bit SPI slave.
- Used for FPGA-to-FPGA and FPGA-to-peripheral tests on the PMOD headers, and as the bench driver for the slave.
- Runs one full-duplex frame of WIDTH bits, MSB first, per START request.
- SCK idles low. MOSI changes on falling SCK; the slave samples on rising SCK. MISO is sampled on falling SCK.

Parameters:
- WIDTH, 16: frame length in bits (min 2).
- CLKDIV, 5: system clocks per SCK half-period (min 1). At 50 MHz this gives 5 MHz SCK.
- IDLE_PULSES, 1: SCK pulses emitted with CSbar high before each frame, so the slave can load its output word (min 0).

Ports:
- CLK, input, 1: system clock, all logic on its rising edge.
- RST, input, 1: synchronous, active-high reset.
- START, input, 1: request a frame; sampled only when BUSY=0.
- TX_DATA, input, WIDTH: word to send; latched on the accepted START edge.
- BUSY, output, 1: high from the cycle after START is accepted until the DONE cycle (exclusive).
- DONE, output, 1: one-cycle pulse when the frame completes.
- RX_DATA, output, WIDTH: captured MISO word; updated in the DONE cycle and held until the next DONE.
- SCK, output, 1: SPI clock.
- MOSI, output, 1: master data out.
- MISO, input, 1: slave data in; may be Z while CSbar is high.
- CSbar, output, 1: active-low chip select.

Behaviour:
- All outputs are registered.
- Reset values: SCK=0, CSbar=1, MOSI=0, BUSY=0, DONE=0, RX_DATA=0. Internal state returns to IDLE and the divider and bit counters clear.
- Divider: a counter spans one half-period of CLKDIV cycles. State and SCK changes occur on terminal count only.
- FSM states: IDLE, PRE, SETUP, SHIFT, HOLD, FIN.
- IDLE:
  - SCK=0, CSbar=1, BUSY=0.
  - On START=1, latch TX_DATA into tx_shift and clear rx_shift.
  - Go to PRE, or to SETUP if IDLE_PULSES=0.
- PRE:
  - CSbar=1.
  - Emit IDLE_PULSES pulses, each SCK high for CLKDIV cycles then low for CLKDIV cycles.
  - Then go to SETUP.
- SETUP:
  - CSbar=0 and MOSI=tx_shift[WIDTH-1], SCK=0, for CLKDIV cycles.
  - Then go to SHIFT.
- SHIFT, repeated WIDTH times:
  - SCK high for CLKDIV cycles.
  - At the falling transition:
    - rx_shift <= {rx_shift[WIDTH-2:0], MISO}, using the pre-edge MISO value.
    - tx_shift shifts left and MOSI takes the next bit, or 0 after the last bit.
  - SCK then stays low for CLKDIV cycles.
  - After the WIDTH-th falling edge, go to HOLD.
- HOLD: CSbar=0, SCK=0 for CLKDIV cycles, then go to FIN.
- FIN:
  - Lasts one cycle: CSbar=1, RX_DATA<=rx_shift, DONE=1, BUSY=0.
  - Returns to IDLE. A START seen in this cycle is accepted, so back-to-back frames have no gap beyond FIN.
- Latency: DONE asserts exactly (2·IDLE_PULSES + 2·WIDTH + 2)·CLKDIV + 1 cycles after the accepting START edge. This is 181 cycles at the defaults.
- Exactly WIDTH rising SCK edges occur while CSbar=0. No SCK edge occurs in the CLKDIV cycles after CSbar falls or before it rises.
- START while BUSY=1 is ignored, and TX_DATA changes while BUSY=1 have no effect.
- RST mid-frame: aborts on that edge. No DONE is issued and RX_DATA resets to 0.
- MISO is never sampled outside SHIFT, so a Z/X value there does not propagate.
- Bit counter wraps only via the FSM. There is no overflow path.

Test Plan:
- Loopback (MISO tied to MOSI), defaults, START with TX_DATA=16'hA5C3 -> RX_DATA=16'hA5C3, DONE high at cycle 181 after START, 16 SCK rising edges while CSbar=0, 1 SCK pulse before CSbar falls.
- Slave model returns 16'h1234, MOSI monitor on rising SCK -> RX_DATA=16'h1234, and the monitor captures 16'hA5C3.
- START re-pulsed at cycles 50 and 100 of a frame with a different TX_DATA -> ignored, single DONE, original word on MOSI.
- RST asserted at cycle 90 of a frame -> next edge: CSbar=1, SCK=0, BUSY=0, RX_DATA=0; no DONE ever.
- START held high continuously, two frames 16'hFFFF then 16'h0001 in loopback -> second frame begins at the FIN cycle, DONE pulses 181 cycles apart, RX_DATA=16'hFFFF then 16'h0001.
- CLKDIV=1, IDLE_PULSES=0, WIDTH=8, TX=8'h81 loopback -> DONE 19 cycles after START, RX_DATA=8'h81, SCK period 2 cycles.

Source files
------------

// File: rtl/spi_master.sv
// SPI master: SCK idles low, MOSI launched on falling SCK, MISO captured on falling SCK.
// Runs one MSB-first full-duplex frame of WIDTH bits per accepted start request.
module spi_master #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned CLKDIV      = 5,
  parameter int unsigned IDLE_PULSES = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] tx_data_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] rx_data_o,
  output logic             sck_o,
  output logic             mosi_o,
  input  logic             miso_i,
  output logic             csbar_o
);

  localparam int unsigned DivW = $clog2(CLKDIV + 1);
  localparam int unsigned BitW = $clog2(WIDTH + 1);
  localparam int unsigned PulW = $clog2(IDLE_PULSES + 2);

  typedef enum logic [2:0] {StIdle, StPre, StSetup, StShift, StHold, StFin} state_e;

  state_e            state_q, state_d;
  logic [DivW-1:0]   div_q, div_d;
  logic [BitW-1:0]   bit_q, bit_d;
  logic [PulW-1:0]   pul_q, pul_d;
  logic [WIDTH-1:0]  tx_q, tx_d;
  logic [WIDTH-1:0]  rx_q, rx_d;
  logic [WIDTH-1:0]  rx_data_q, rx_data_d;
  logic              sck_q, sck_d;
  logic              cs_q, cs_d;
  logic              mosi_q, mosi_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              div_tc;

  assign div_tc = (div_q == DivW'(CLKDIV - 1));

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    bit_d     = bit_q;
    pul_d     = pul_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    rx_data_d = rx_data_q;
    sck_d     = sck_q;
    cs_d      = cs_q;
    mosi_d    = mosi_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    if (state_q != StIdle && state_q != StFin) begin
      div_d = div_tc ? '0 : div_q + 1'b1;
    end

    unique case (state_q)
      StIdle, StFin: begin
        if (state_q == StFin) begin
          done_d    = 1'b1;
          cs_d      = 1'b1;
          rx_data_d = rx_q;
          busy_d    = 1'b0;
          state_d   = StIdle;
        end
        // FIN also accepts a new request so back-to-back frames add no idle cycle.
        if (start_i) begin
          tx_d   = tx_data_i;
          rx_d   = '0;
          div_d  = '0;
          bit_d  = '0;
          pul_d  = '0;
          busy_d = 1'b1;
          if (IDLE_PULSES == 0) begin
            state_d = StSetup;
            cs_d    = 1'b0;
            mosi_d  = tx_data_i[WIDTH-1];
          end else begin
            state_d = StPre;
            sck_d   = 1'b1;
          end
        end
      end
      StPre: begin
        if (div_tc) begin
          if (sck_q) begin
            sck_d = 1'b0;
          end else if (pul_q == PulW'(IDLE_PULSES - 1)) begin
            state_d = StSetup;
            cs_d    = 1'b0;
            mosi_d  = tx_q[WIDTH-1];
          end else begin
            pul_d = pul_q + 1'b1;
            sck_d = 1'b1;
          end
        end
      end
      StSetup: begin
        if (div_tc) begin
          state_d = StShift;
          sck_d   = 1'b1;
        end
      end
      StShift: begin
        if (div_tc) begin
          if (sck_q) begin
            sck_d  = 1'b0;
            rx_d   = {rx_q[WIDTH-2:0], miso_i};
            tx_d   = {tx_q[WIDTH-2:0], 1'b0};
            // Zeros shift in, so this drives 0 after the last bit.
            mosi_d = tx_q[WIDTH-2];
            bit_d  = bit_q + 1'b1;
          end else if (bit_q == BitW'(WIDTH)) begin
            state_d = StHold;
          end else begin
            sck_d = 1'b1;
          end
        end
      end
      StHold: begin
        if (div_tc) state_d = StFin;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      div_q     <= '0;
      bit_q     <= '0;
      pul_q     <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
      rx_data_q <= '0;
      sck_q     <= 1'b0;
      cs_q      <= 1'b1;
      mosi_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      bit_q     <= bit_d;
      pul_q     <= pul_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      rx_data_q <= rx_data_d;
      sck_q     <= sck_d;
      cs_q      <= cs_d;
      mosi_q    <= mosi_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign rx_data_o = rx_data_q;
  assign sck_o     = sck_q;
  assign mosi_o    = mosi_q;
  assign csbar_o   = cs_q;

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: two configurations checked every cycle against a frame-timeline model.
module tb_spi_master;

  localparam int AW = 16, AD = 5, AP = 1;
  localparam int AN = (2 * AP + 2 * AW + 2) * AD + 1;
  localparam int BW = 8, BD = 1, BP = 0;
  localparam int BN = (2 * BP + 2 * BW + 2) * BD + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        start_a = 1'b0;
  logic [15:0] tx_a = '0;
  logic        busy_a, done_a, sck_a, mosi_a, miso_a, cs_a;
  logic [15:0] rx_a;
  logic        start_b = 1'b0;
  logic [7:0]  tx_b = '0;
  logic        busy_b, done_b, sck_b, mosi_b, miso_b, cs_b;
  logic [7:0]  rx_b;

  logic        loop_a = 1'b1;
  logic [15:0] slave_word = '0;
  logic        slave_bit = 1'b0;
  logic        sl_prev = 1'b0;
  int          sl_cnt = 0;

  assign miso_a = loop_a ? mosi_a : slave_bit;
  assign miso_b = mosi_b;

  spi_master #(.WIDTH(AW), .CLKDIV(AD), .IDLE_PULSES(AP)) u_dut_a (
    .clk_i(clk), .rst_i(rst), .start_i(start_a), .tx_data_i(tx_a), .busy_o(busy_a),
    .done_o(done_a), .rx_data_o(rx_a), .sck_o(sck_a), .mosi_o(mosi_a), .miso_i(miso_a),
    .csbar_o(cs_a)
  );

  spi_master #(.WIDTH(BW), .CLKDIV(BD), .IDLE_PULSES(BP)) u_dut_b (
    .clk_i(clk), .rst_i(rst), .start_i(start_b), .tx_data_i(tx_b), .busy_o(busy_b),
    .done_o(done_b), .rx_data_o(rx_b), .sck_o(sck_b), .mosi_o(mosi_b), .miso_i(miso_b),
    .csbar_o(cs_b)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // {sck, csbar, mosi} k cycles after the accepting edge of a frame.
  function automatic logic [2:0] exp_out(input int k, input logic [15:0] tx, input int w,
                                         input int d, input int p);
    int pre, j, b, ph;
    pre = 2 * p * d;
    if (k < pre) return {((k % (2 * d)) < d), 1'b1, 1'b0};
    if (k < pre + d) return {1'b0, 1'b0, tx[w-1]};
    if (k < pre + d + 2 * w * d) begin
      j  = k - pre - d;
      b  = j / (2 * d);
      ph = j % (2 * d);
      if (ph < d) return {1'b1, 1'b0, tx[w-1-b]};
      return {1'b0, 1'b0, (b + 1 < w) ? tx[w-2-b] : 1'b0};
    end
    return 3'b000;
  endfunction

  // Behavioural slave: word presented MSB first, advanced after each falling SCK.
  always @(posedge clk) begin
    #1;
    if (cs_a) begin
      sl_cnt    = 0;
      slave_bit = 1'($urandom_range(0, 1));
    end else begin
      if (sl_prev && !sck_a) sl_cnt++;
      slave_bit = (sl_cnt < 16) ? slave_word[15-sl_cnt] : 1'b0;
    end
    sl_prev = sck_a;
  end

  // Model state: active frame, cycles since accept, latched word, expected capture.
  bit          a_act = 0, a_done = 0, a_sck_prev = 0;
  int          a_k = 0, a_rise_cs = 0, a_rise_pre = 0, a_dones = 0;
  logic [15:0] a_tx = '0, a_frx = '0, a_rx = '0, a_mon = '0;
  logic [15:0] a_rxq[$];
  bit          b_act = 0, b_done = 0, b_sck_prev = 0;
  int          b_k = 0, b_rise_cs = 0;
  logic [7:0]  b_tx = '0, b_rx = '0;

  always @(negedge clk) begin
    logic [2:0] e;
    e = a_act ? exp_out(a_k, a_tx, AW, AD, AP) : 3'b010;
    chk("a_sck", 32'(sck_a), 32'(e[2]));
    chk("a_csbar", 32'(cs_a), 32'(e[1]));
    chk("a_mosi", 32'(mosi_a), 32'(e[0]));
    chk("a_busy", 32'(busy_a), 32'(a_act));
    chk("a_done", 32'(done_a), 32'(a_done));
    chk("a_rx", 32'(rx_a), 32'(a_rx));
    if (sck_a && !a_sck_prev) begin
      if (!cs_a) begin
        a_rise_cs++;
        a_mon = {a_mon[14:0], mosi_a};
      end else begin
        a_rise_pre++;
      end
    end
    a_sck_prev = sck_a;
    if (done_a) begin
      a_dones++;
      a_rxq.push_back(rx_a);
    end
    if (rst) begin
      a_act = 0; a_k = 0; a_done = 0; a_rx = '0;
    end else begin
      a_done = 0;
      if (a_act && a_k == AN - 1) begin
        a_done = 1; a_rx = a_frx; a_act = 0;
      end else if (a_act) begin
        a_k++;
      end
      if (!a_act && start_a) begin
        a_act = 1; a_k = 0; a_tx = tx_a;
        a_frx = loop_a ? tx_a : slave_word;
      end
    end
  end

  always @(negedge clk) begin
    logic [2:0] e;
    e = b_act ? exp_out(b_k, {8'h00, b_tx}, BW, BD, BP) : 3'b010;
    chk("b_sck", 32'(sck_b), 32'(e[2]));
    chk("b_csbar", 32'(cs_b), 32'(e[1]));
    chk("b_mosi", 32'(mosi_b), 32'(e[0]));
    chk("b_busy", 32'(busy_b), 32'(b_act));
    chk("b_done", 32'(done_b), 32'(b_done));
    chk("b_rx", 32'(rx_b), 32'(b_rx));
    if (sck_b && !b_sck_prev && !cs_b) b_rise_cs++;
    b_sck_prev = sck_b;
    if (rst) begin
      b_act = 0; b_k = 0; b_done = 0; b_rx = '0;
    end else begin
      b_done = 0;
      if (b_act && b_k == BN - 1) begin
        b_done = 1; b_rx = b_tx; b_act = 0;
      end else if (b_act) begin
        b_k++;
      end
      if (!b_act && start_b) begin
        b_act = 1; b_k = 0; b_tx = tx_b;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Counts edges from the accepting edge until DONE is seen; gives up after 1000.
  task automatic wait_done(input bit sel, output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!(sel ? done_b : done_a) && n < 1000);
    #1;
  endtask

  task automatic begin_a(input logic [15:0] tx);
    tx_a = tx;
    start_a = 1'b1;
    @(posedge clk);
    #2;
    start_a = 1'b0;
  endtask

  int n, n2, rst_at;

  initial begin
    cyc(4);
    chk("reset_csbar", 32'(cs_a), 32'd1);
    chk("reset_sck", 32'(sck_a), 32'd0);
    chk("reset_busy", 32'(busy_a), 32'd0);
    chk("reset_rx", 32'(rx_a), 32'd0);
    rst = 1'b0;
    cyc(3);

    // Loopback A5C3: latency, capture, edge counts.
    loop_a = 1'b1; a_rise_cs = 0; a_rise_pre = 0;
    begin_a(16'hA5C3);
    wait_done(1'b0, n);
    chk("lb_latency", 32'(n), 32'd181);
    chk("lb_rx", 32'(rx_a), 32'hA5C3);
    chk("lb_rises_cs", 32'(a_rise_cs), 32'd16);
    chk("lb_pre_pulses", 32'(a_rise_pre), 32'd1);
    cyc(5);

    // Slave returns 1234 while the MOSI monitor captures the sent word.
    loop_a = 1'b0; slave_word = 16'h1234;
    begin_a(16'hA5C3);
    wait_done(1'b0, n);
    chk("slave_rx", 32'(rx_a), 32'h1234);
    chk("slave_mosi_mon", 32'(a_mon), 32'hA5C3);
    cyc(5);

    // START re-pulsed mid-frame with a different word is ignored.
    loop_a = 1'b1; a_dones = 0;
    begin_a(16'hA5C3);
    cyc(47);
    tx_a = 16'h5A5A; start_a = 1'b1; cyc(1); start_a = 1'b0;
    cyc(49);
    tx_a = 16'h0F0F; start_a = 1'b1; cyc(1); start_a = 1'b0;
    cyc(100);
    chk("restart_dones", 32'(a_dones), 32'd1);
    chk("restart_rx", 32'(rx_a), 32'hA5C3);
    chk("restart_mosi_mon", 32'(a_mon), 32'hA5C3);

    // Reset mid-frame aborts immediately and no DONE follows.
    a_dones = 0;
    begin_a(16'h3C96);
    cyc(88);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_csbar", 32'(cs_a), 32'd1);
    chk("abort_sck", 32'(sck_a), 32'd0);
    chk("abort_busy", 32'(busy_a), 32'd0);
    chk("abort_rx", 32'(rx_a), 32'd0);
    #1;
    rst = 1'b0;
    cyc(300);
    chk("abort_no_done", 32'(a_dones), 32'd0);

    // START held high: second frame accepted in the FIN cycle.
    a_rxq.delete();
    tx_a = 16'hFFFF; start_a = 1'b1;
    @(posedge clk);
    #2;
    tx_a = 16'h0001;
    wait_done(1'b0, n);
    start_a = 1'b0;
    wait_done(1'b0, n2);
    chk("b2b_first_latency", 32'(n), 32'd181);
    chk("b2b_spacing", 32'(n2), 32'd181);
    cyc(10);
    chk("b2b_dones", 32'(a_rxq.size()), 32'd2);
    if (a_rxq.size() == 2) begin
      chk("b2b_rx0", 32'(a_rxq[0]), 32'hFFFF);
      chk("b2b_rx1", 32'(a_rxq[1]), 32'h0001);
    end

    // Randomized frames: mode, words, ignored restarts, occasional aborts.
    for (int it = 0; it < 30; it++) begin
      loop_a = 1'($urandom_range(0, 1));
      slave_word = 16'($urandom);
      begin_a(16'($urandom));
      rst_at = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, AN - 2)) : -1;
      for (int c = 1; c < AN + 4; c++) begin
        start_a = (c < AN - 3) && (rst_at < 0 || c < rst_at) && ($urandom_range(0, 9) == 0);
        tx_a = 16'($urandom);
        rst = (c == rst_at);
        cyc(1);
      end
      start_a = 1'b0; rst = 1'b0;
      cyc(2);
    end

    // Fast configuration: WIDTH=8, CLKDIV=1, no idle pulses.
    b_rise_cs = 0;
    tx_b = 8'h81; start_b = 1'b1;
    @(posedge clk);
    #2;
    start_b = 1'b0;
    wait_done(1'b1, n);
    chk("fast_latency", 32'(n), 32'd19);
    chk("fast_rx", 32'(rx_b), 32'h81);
    chk("fast_rises_cs", 32'(b_rise_cs), 32'd8);
    cyc(3);
    for (int it = 0; it < 20; it++) begin
      tx_b = 8'($urandom); start_b = 1'b1;
      cyc(1);
      for (int c = 1; c < BN + 3; c++) begin
        start_b = (c < BN - 3) && ($urandom_range(0, 3) == 0);
        tx_b = 8'($urandom);
        cyc(1);
      end
      start_b = 1'($urandom_range(0, 1));
      tx_b = 8'($urandom);
      cyc(1);
      start_b = 1'b0;
      cyc(BN + 3);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
